// File: rtl/down_counter_nbit.sv
// Parameterized binary down counter with parallel load, count enable, and wrap or one-shot terminal handling.
// q, tc and done are all registered, so no input reaches an output combinationally.
module down_counter_nbit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic             o_dbg_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_done;

  // Edge priority is reset, then load, then counting; load also clears any pending terminal pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_q     <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_state <= ST_RUN;
      r_q     <= load_val;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_tc <= 1'b0;
          if (en) begin
            if (r_q != '0) begin
              r_q <= r_q - ONE;
            end else if (!mode) begin
              r_q  <= MAX;
              r_tc <= 1'b1;
            end else begin
              // One-shot terminal: count stays at zero until a load or reset.
              r_tc    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          r_tc <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
          r_tc    <= 1'b0;
        end
      endcase
    end
  end

  assign q           = r_q;
  assign tc          = r_tc;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_down_counter_nbit.sv
// Directed bench for down_counter_nbit: a WIDTH=2 wrap run and a WIDTH=4 one-shot/load/reset run.
// Expected {state, done, tc, q} words are queued when a step is driven and popped after the edge.
module tb_down_counter_nbit;

  logic       clk;
  logic       rst;
  logic       en2, load2, mode2;
  logic [1:0] load_val2;
  logic [1:0] q2;
  logic       tc2, done2, st2;
  logic       en4, load4, mode4;
  logic [3:0] load_val4;
  logic [3:0] q4;
  logic       tc4, done4, st4;

  logic [7:0] exp_q[$];
  int         checks;
  int         failures;
  logic [3:0] rnd_val;

  down_counter_nbit #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .load(load2), .load_val(load_val2), .mode(mode2),
    .q(q2), .tc(tc2), .done(done2), .o_dbg_state(st2)
  );

  down_counter_nbit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .load(load4), .load_val(load_val4), .mode(mode4),
    .q(q4), .tc(tc4), .done(done4), .o_dbg_state(st4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pack2();
    return {st2, 1'b0, done2, tc2, 2'b00, q2};
  endfunction

  function automatic logic [7:0] pack4();
    return {st4, 1'b0, done4, tc4, q4};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={st,0,done,tc,q}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drivers: apply inputs, queue the expectation, sample 1 ns after the edge.
  task automatic step2(input string tag, input logic en, input logic mode,
                       input logic [1:0] eq, input logic etc, input logic edone);
    en2 = en; mode2 = mode; load2 = 1'b0;
    exp_q.push_back({1'b0, 1'b0, edone, etc, 2'b00, eq});
    @(posedge clk); #1;
    check(tag, pack2(), exp_q.pop_front());
  endtask

  task automatic step4(input string tag, input logic load, input logic [3:0] lv,
                       input logic en, input logic mode, input logic [3:0] eq,
                       input logic etc, input logic edone, input logic est);
    load4 = load; load_val4 = lv; en4 = en; mode4 = mode;
    exp_q.push_back({est, 1'b0, edone, etc, eq});
    @(posedge clk); #1;
    check(tag, pack4(), exp_q.pop_front());
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    en2 = 1'b0; load2 = 1'b0; mode2 = 1'b0; load_val2 = 2'b00;
    en4 = 1'b0; load4 = 1'b0; mode4 = 1'b0; load_val4 = 4'h0;
    #2;
    check("reset_w2", pack2(), 8'h00);
    check("reset_w4", pack4(), 8'h00);
    #8 rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_w2", pack2(), 8'h00);

    // WIDTH=2 wrap: 0 -> 3 (tc) -> 2 -> 1 -> 0 -> 3 (tc) ...
    step2("w2_c1",  1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    step2("w2_c2",  1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    step2("w2_c3",  1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    step2("w2_c4",  1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step2("w2_c5",  1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    step2("w2_c6",  1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    step2("w2_c7",  1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    step2("w2_c8",  1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step2("w2_c9",  1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    step2("w2_c10", 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    step2("w2_hold", 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    check("w4_idle", pack4(), 8'h00);

    // WIDTH=4 one-shot from 3
    step4("os_load3", 1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step4("os_2",     1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    step4("os_1",     1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    step4("os_0",     1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step4("os_term",  1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      step4("os_halt", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);

    // Reload out of HALT, then terminate again
    step4("halt_load2", 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    step4("rl_1",       1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    step4("rl_0",       1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step4("rl_term",    1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);

    // Load with en high: load wins
    step4("load9_en", 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    step4("cnt_8",    1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
    step4("cnt_7",    1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step4("en_low_hold7", 1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
    step4("cnt_6",    1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
    step4("cnt_5",    1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset pulse between edges
    en4 = 1'b0;
    rst = 1'b1;
    #2;
    check("async_rst", pack4(), 8'h00);
    #1 rst = 1'b0;
    step4("rst_wrap", 1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    step4("rst_14",   1'b0, 4'd0, 1'b1, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0);

    // Load beats a coincident terminal event
    step4("load0",      1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step4("load_vs_tc", 1'b1, 4'd4, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    step4("mode_ignored", 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);

    // Random load value then one decrement
    rnd_val = 4'($urandom_range(2, 15));
    step4("rnd_load", 1'b1, rnd_val, 1'b0, 1'b0, rnd_val, 1'b0, 1'b0, 1'b0);
    step4("rnd_dec",  1'b0, 4'd0, 1'b1, 1'b0, rnd_val - 4'd1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
